// File: rtl/ahb_matrix_decoder_nport.sv
// Per-master AHB matrix address decoder: picks an output stage (or the built-in default slave),
// returns the data-phase response, and records unmapped-access debug information.
module ahb_matrix_decoder_nport #(
  parameter int unsigned                 NUM_PORTS    = 4,
  parameter logic [22*NUM_PORTS-1:0]     REGION_BASE  = {NUM_PORTS{22'h0}},
  parameter logic [22*NUM_PORTS-1:0]     REGION_LIMIT = {NUM_PORTS{22'h0}},
  parameter int unsigned                 ERR_CNT_W    = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HREADYS,
  input  logic                   sel_dec,
  input  logic [21:0]            decode_addr_dec,
  input  logic [1:0]             trans_dec,
  input  logic [NUM_PORTS-1:0]   active_in,
  input  logic [NUM_PORTS-1:0]   readyout_in,
  input  logic [2*NUM_PORTS-1:0] resp_in,
  input  logic [32*NUM_PORTS-1:0] rdata_in,
  input  logic [32*NUM_PORTS-1:0] ruser_in,
  input  logic                   err_clr,
  output logic [NUM_PORTS-1:0]   sel_out,
  output logic                   active_dec,
  output logic                   HREADYOUTS,
  output logic [1:0]             HRESPS,
  output logic [31:0]            HRDATAS,
  output logic [31:0]            HRUSERS,
  output logic                   err_valid,
  output logic [21:0]            err_addr,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int unsigned PW = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0] DFT_PORT = PW'(NUM_PORTS);

  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dft_state_e;

  logic [PW-1:0] dec_port;
  logic [PW-1:0] addr_port;
  logic [PW-1:0] data_port;
  logic          hit_found;
  logic          dft_accept;
  logic          dft_ready;
  logic [1:0]    dft_resp;
  dft_state_e    dft_state;
  dft_state_e    dft_state_nxt;

  // Region decode; the first (lowest-index) matching region wins on overlap
  always_comb begin
    dec_port  = DFT_PORT;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!hit_found &&
          decode_addr_dec >= REGION_BASE[22*i +: 22] &&
          decode_addr_dec <= REGION_LIMIT[22*i +: 22]) begin
        dec_port  = PW'(i);
        hit_found = 1'b1;
      end
    end
  end

  // IDLE address phases stay on the current real port so the output stage is not switched needlessly
  always_comb begin
    addr_port = dec_port;
    if (trans_dec == 2'b00 && data_port < DFT_PORT) begin
      addr_port = data_port;
    end
  end

  always_comb begin
    sel_out    = '0;
    active_dec = 1'b1;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (addr_port == PW'(i)) begin
        sel_out[i] = sel_dec;
        active_dec = active_in[i];
      end
    end
  end

  assign dft_accept = HREADYS & sel_dec & (addr_port == DFT_PORT) & trans_dec[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      data_port <= '0;
    end else if (HREADYS) begin
      data_port <= addr_port;
    end
  end

  // Data-phase response mux; values outside 0..NUM_PORTS are unreachable and left as don't-care
  always_comb begin
    HREADYOUTS = 1'bx;
    HRESPS     = 'x;
    HRDATAS    = 'x;
    HRUSERS    = 'x;
    if (data_port == DFT_PORT) begin
      HREADYOUTS = dft_ready;
      HRESPS     = dft_resp;
      HRDATAS    = '0;
      HRUSERS    = '0;
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (data_port == PW'(i)) begin
        HREADYOUTS = readyout_in[i];
        HRESPS     = resp_in[2*i +: 2];
        HRDATAS    = rdata_in[32*i +: 32];
        HRUSERS    = ruser_in[32*i +: 32];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dft_state <= D_IDLE;
    end else begin
      dft_state <= dft_state_nxt;
    end
  end

  // Default slave: two-cycle ERROR that cannot be cancelled once accepted
  always_comb begin
    dft_state_nxt = dft_state;
    case (dft_state)
      D_IDLE:  if (dft_accept) dft_state_nxt = D_ERR1;
      D_ERR1:  dft_state_nxt = D_ERR2;
      D_ERR2:  dft_state_nxt = dft_accept ? D_ERR1 : D_IDLE;
      default: dft_state_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    dft_ready = 1'b1;
    dft_resp  = 2'b00;
    case (dft_state)
      D_ERR1:  begin dft_ready = 1'b0; dft_resp = 2'b01; end
      D_ERR2:  begin dft_ready = 1'b1; dft_resp = 2'b01; end
      default: begin dft_ready = 1'b1; dft_resp = 2'b00; end
    endcase
  end

  // Debug capture; a new error in the clear cycle survives the clear
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_cnt   <= '0;
    end else if (dft_accept) begin
      err_valid <= 1'b1;
      if (!err_valid || err_clr) begin
        err_addr <= decode_addr_dec;
      end
      if (err_clr) begin
        err_cnt <= ERR_CNT_W'(1);
      end else if (err_cnt != {ERR_CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_cnt   <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_matrix_decoder_nport.sv
// Directed bench for ahb_matrix_decoder_nport: two ports plus default slave, with a second
// instance using a 2-bit error counter to observe saturation.
module tb_ahb_matrix_decoder_nport;

  localparam int unsigned NP = 2;
  localparam logic [43:0] BASE  = {22'h080000, 22'h000000};
  localparam logic [43:0] LIMIT = {22'h08003F, 22'h00005F};

  logic        HCLK = 1'b0;
  logic        HRESET, HREADYS, sel_dec, err_clr;
  logic [21:0] decode_addr_dec;
  logic [1:0]  trans_dec;
  logic [1:0]  active_in, readyout_in;
  logic [3:0]  resp_in;
  logic [63:0] rdata_in, ruser_in;

  logic [1:0]  sel_out, sel_out2;
  logic        active_dec, active_dec2, HREADYOUTS, HREADYOUTS2;
  logic [1:0]  HRESPS, HRESPS2;
  logic [31:0] HRDATAS, HRDATAS2, HRUSERS, HRUSERS2;
  logic        err_valid, err_valid2;
  logic [21:0] err_addr, err_addr2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_matrix_decoder_nport #(.NUM_PORTS(NP), .REGION_BASE(BASE), .REGION_LIMIT(LIMIT), .ERR_CNT_W(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_in(active_in),
    .readyout_in(readyout_in), .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
    .err_clr(err_clr), .sel_out(sel_out), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS), .err_valid(err_valid),
    .err_addr(err_addr), .err_cnt(err_cnt));

  ahb_matrix_decoder_nport #(.NUM_PORTS(NP), .REGION_BASE(BASE), .REGION_LIMIT(LIMIT), .ERR_CNT_W(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_in(active_in),
    .readyout_in(readyout_in), .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
    .err_clr(err_clr), .sel_out(sel_out2), .active_dec(active_dec2), .HREADYOUTS(HREADYOUTS2),
    .HRESPS(HRESPS2), .HRDATAS(HRDATAS2), .HRUSERS(HRUSERS2), .err_valid(err_valid2),
    .err_addr(err_addr2), .err_cnt(err_cnt2));

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [21:0] addr;
    logic        hr;
    logic [1:0]  rdy;
    logic [1:0]  e_sel;
    logic        e_act;
    logic        e_rdy;
    logic [1:0]  e_resp;
    int          e_dp;
    int          e_cnt;
    logic [21:0] e_eaddr;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] t, input logic [21:0] a, input logic h);
    sel_dec = s; trans_dec = t; decode_addr_dec = a; HREADYS = h;
  endtask

  function automatic logic [31:0] exp_rdata(input int dp);
    return (dp == 0) ? 32'hAAAA_0000 : (dp == 1) ? 32'hBBBB_0001 : 32'h0;
  endfunction

  function automatic logic [31:0] exp_ruser(input int dp);
    return (dp == 0) ? 32'h1111_0000 : (dp == 1) ? 32'h2222_0001 : 32'h0;
  endfunction

  initial begin
    //          sel  trans  addr        hr    rdy    e_sel  act   rdy   resp   dp cnt eaddr
    tbl[0]  = '{1'b0, 2'b00, 22'h000000, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 0, 0, 22'h000000};
    tbl[1]  = '{1'b1, 2'b10, 22'h000010, 1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 2'b00, 0, 0, 22'h000000};
    tbl[2]  = '{1'b0, 2'b00, 22'h000010, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 0, 0, 22'h000000};
    tbl[3]  = '{1'b1, 2'b10, 22'h080001, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 0, 0, 22'h000000};
    tbl[4]  = '{1'b1, 2'b10, 22'h080001, 1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 2'b00, 0, 0, 22'h000000};
    tbl[5]  = '{1'b1, 2'b00, 22'h3FFFFF, 1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 2'b00, 1, 0, 22'h000000};
    tbl[6]  = '{1'b0, 2'b00, 22'h3FFFFF, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1, 0, 22'h000000};
    tbl[7]  = '{1'b1, 2'b10, 22'h100000, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1, 0, 22'h000000};
    tbl[8]  = '{1'b0, 2'b00, 22'h000000, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2, 1, 22'h100000};
    tbl[9]  = '{1'b1, 2'b10, 22'h200000, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 2, 1, 22'h100000};
    tbl[10] = '{1'b0, 2'b00, 22'h000000, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2, 2, 22'h100000};
    tbl[11] = '{1'b0, 2'b00, 22'h000000, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'b01, 2, 2, 22'h100000};
    tbl[12] = '{1'b1, 2'b00, 22'h000000, 1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 2'b00, 0, 2, 22'h100000};
    tbl[13] = '{1'b1, 2'b01, 22'h100000, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 0, 2, 22'h100000};
    tbl[14] = '{1'b0, 2'b00, 22'h3FFFFF, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 2, 2, 22'h100000};
    tbl[15] = '{1'b1, 2'b10, 22'h00005F, 1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 2'b00, 2, 2, 22'h100000};
    tbl[16] = '{1'b1, 2'b10, 22'h08003F, 1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 2'b00, 0, 2, 22'h100000};
    tbl[17] = '{1'b1, 2'b10, 22'h080040, 1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1, 2, 22'h100000};
    tbl[18] = '{1'b0, 2'b00, 22'h000000, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2, 3, 22'h100000};
    tbl[19] = '{1'b0, 2'b00, 22'h000000, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'b01, 2, 3, 22'h100000};

    HRESET = 1'b1; err_clr = 1'b0;
    drive(1'b0, 2'b00, 22'h0, 1'b0);
    active_in   = 2'b10;
    readyout_in = 2'b01;
    resp_in     = 4'b1110;
    rdata_in    = {32'hBBBB_0001, 32'hAAAA_0000};
    ruser_in    = {32'h2222_0001, 32'h1111_0000};
    repeat (2) tick();
    HRESET = 1'b0;
    #3;
    chk("reset HREADYOUTS", 32'(HREADYOUTS), 32'(1'b1));
    chk("reset HRESPS", 32'(HRESPS), 32'(2'b10));
    chk("reset HRDATAS", HRDATAS, 32'hAAAA_0000);
    chk("reset err_valid", 32'(err_valid), 32'd0);
    chk("reset err_addr", 32'(err_addr), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    resp_in = 4'b0000;
    tick();

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].sel, tbl[r].trans, tbl[r].addr, tbl[r].hr);
      readyout_in = tbl[r].rdy;
      #3;
      chk($sformatf("row%0d sel_out", r), 32'(sel_out), 32'(tbl[r].e_sel));
      chk($sformatf("row%0d active_dec", r), 32'(active_dec), 32'(tbl[r].e_act));
      chk($sformatf("row%0d HREADYOUTS", r), 32'(HREADYOUTS), 32'(tbl[r].e_rdy));
      chk($sformatf("row%0d HRESPS", r), 32'(HRESPS), 32'(tbl[r].e_resp));
      chk($sformatf("row%0d HRDATAS", r), HRDATAS, exp_rdata(tbl[r].e_dp));
      chk($sformatf("row%0d HRUSERS", r), HRUSERS, exp_ruser(tbl[r].e_dp));
      chk($sformatf("row%0d err_cnt", r), 32'(err_cnt), 32'(tbl[r].e_cnt));
      chk($sformatf("row%0d err_cnt_w2", r), 32'(err_cnt2), 32'((tbl[r].e_cnt > 3) ? 3 : tbl[r].e_cnt));
      chk($sformatf("row%0d err_valid", r), 32'(err_valid), 32'(tbl[r].e_cnt != 0));
      chk($sformatf("row%0d err_addr", r), 32'(err_addr), 32'(tbl[r].e_eaddr));
      tick();
    end

    // Clear coinciding with a new error: the new error is kept
    readyout_in = 2'b11;
    drive(1'b1, 2'b10, 22'h300000, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    drive(1'b0, 2'b00, 22'h0, 1'b0);
    #3;
    chk("clr+err err_valid", 32'(err_valid), 32'd1);
    chk("clr+err err_addr", 32'(err_addr), 32'h300000);
    chk("clr+err err_cnt", 32'(err_cnt), 32'd1);
    chk("clr+err err_cnt_w2", 32'(err_cnt2), 32'd1);
    chk("clr+err HREADYOUTS", 32'(HREADYOUTS), 32'd0);
    tick();
    drive(1'b0, 2'b00, 22'h0, 1'b1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #3;
    chk("clr err_valid", 32'(err_valid), 32'd0);
    chk("clr err_addr", 32'(err_addr), 32'd0);
    chk("clr err_cnt", 32'(err_cnt), 32'd0);

    // Five back-to-back errors: narrow counter saturates, first address retained
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b10, 22'(22'h100000 + k), 1'b1);
      tick();
      drive(1'b0, 2'b00, 22'h0, 1'b0);
      tick();
    end
    drive(1'b0, 2'b00, 22'h0, 1'b1);
    #3;
    chk("sat err_cnt", 32'(err_cnt), 32'd5);
    chk("sat err_cnt_w2", 32'(err_cnt2), 32'd3);
    chk("sat err_addr", 32'(err_addr), 32'h100000);
    chk("sat err_addr_w2", 32'(err_addr2), 32'h100000);
    tick();

    // Reset in the middle of an ERROR response
    drive(1'b1, 2'b10, 22'h100000, 1'b1);
    tick();
    drive(1'b0, 2'b00, 22'h0, 1'b0);
    HRESET = 1'b1;
    #3;
    chk("pre-reset ERR1 HREADYOUTS", 32'(HREADYOUTS), 32'd0);
    tick();
    HRESET = 1'b0;
    readyout_in = 2'b01;
    resp_in = 4'b0010;
    #3;
    chk("midreset HREADYOUTS", 32'(HREADYOUTS), 32'd1);
    chk("midreset HRESPS", 32'(HRESPS), 32'(2'b10));
    chk("midreset HRDATAS", HRDATAS, 32'hAAAA_0000);
    chk("midreset err_cnt", 32'(err_cnt), 32'd0);
    chk("midreset err_valid", 32'(err_valid), 32'd0);
    chk("midreset err_valid_w2", 32'(err_valid2), 32'd0);
    drive(1'b1, 2'b01, 22'h3FFFFF, 1'b1);
    tick();
    resp_in = 4'b0000;
    drive(1'b0, 2'b00, 22'h0, 1'b0);
    #3;
    chk("post-reset dft HREADYOUTS", 32'(HREADYOUTS), 32'd1);
    chk("post-reset dft HRESPS", 32'(HRESPS), 32'd0);
    chk("post-reset dft HRDATAS", HRDATAS, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
